// File: rtl/fetch_unit_pkg.sv
// Shared fetch front-end definitions: FSM states, fetch granule and the NOP encoding.
package fetch_unit_pkg;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_DRAIN = 1'b1
  } fetch_state_t;

  localparam int unsigned INSTR_ALIGN = 4;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

endpackage

// File: rtl/fetch_unit_fifo.sv
// Prefetch FIFO holding {instr, pc} entries; flush wins over push, head is read combinationally.
module fetch_unit_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 48
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Decoupled instruction fetch: credit-limited requests, in-order prefetch FIFO, redirect drain.
// Optional FETCH_PERF_EN adds fetch_cnt/flush_cnt performance counters.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned         PC_WIDTH    = 16,
  parameter int unsigned         INSTR_WIDTH = 32,
  parameter int unsigned         FIFO_DEPTH  = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   sysclk,
  input  logic                   rst,
  input  logic                   halt,
  input  logic                   redirect,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [PC_WIDTH-1:0]    mem_req_addr,
  input  logic                   mem_resp_valid,
  input  logic [INSTR_WIDTH-1:0] mem_resp_data,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0]    instr_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]            fetch_cnt,
  output logic [31:0]            flush_cnt
`endif
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SW = CW + 1;
  localparam int unsigned EW = INSTR_WIDTH + PC_WIDTH;

  fetch_state_t        state, state_nxt;
  logic [PC_WIDTH-1:0] fetch_pc, fetch_pc_nxt;
  logic [CW-1:0]       outstanding, outstanding_nxt;
  logic [CW-1:0]       discard, discard_nxt;
  logic [CW-1:0]       fifo_count;
  logic [SW-1:0]       occupancy;
  logic [PC_WIDTH-1:0] resp_pc;
  logic [EW-1:0]       head;
  logic                credit, req_fire, push, pop;

  // Buffered plus in-flight words never exceed the FIFO, so a response always has a slot.
  assign occupancy     = SW'(fifo_count) + SW'(outstanding);
  assign credit        = occupancy < SW'(FIFO_DEPTH);
  assign mem_req_valid = rst && (state == ST_FETCH) && !halt && !redirect && credit;
  assign mem_req_addr  = fetch_pc;
  assign req_fire      = mem_req_valid && mem_req_ready;

  // Requests since the last redirect are contiguous, so the oldest in-flight PC trails fetch_pc.
  assign resp_pc = fetch_pc - PC_WIDTH'(INSTR_ALIGN * 32'(outstanding));
  assign push    = mem_resp_valid && (state == ST_FETCH) && !redirect;
  assign pop     = instr_valid && instr_ready;

  always_comb begin
    state_nxt       = state;
    fetch_pc_nxt    = fetch_pc;
    discard_nxt     = discard;
    outstanding_nxt = outstanding + CW'(req_fire) - CW'(mem_resp_valid);
    if (req_fire) fetch_pc_nxt = fetch_pc + PC_WIDTH'(INSTR_ALIGN);
    case (state)
      ST_FETCH: begin
        if (redirect) begin
          fetch_pc_nxt = redirect_pc;
          discard_nxt  = outstanding_nxt;
          if (outstanding_nxt != '0) state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (redirect) fetch_pc_nxt = redirect_pc;
        if (mem_resp_valid && (discard != '0)) begin
          discard_nxt = discard - CW'(1);
          if (discard == CW'(1)) state_nxt = ST_FETCH;
        end
      end
      default: state_nxt = ST_FETCH;
    endcase
  end

  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      state       <= ST_FETCH;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      state       <= state_nxt;
      fetch_pc    <= fetch_pc_nxt;
      outstanding <= outstanding_nxt;
      discard     <= discard_nxt;
    end
  end

  fetch_unit_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (sysclk),
    .rst_n (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata ({mem_resp_data, resp_pc}),
    .rdata (head),
    .count (fifo_count)
  );

  // Head fields read as zero while empty so reset and flush present clean outputs.
  assign instr_valid = fifo_count != '0;
  assign instr       = instr_valid ? head[EW-1 -: INSTR_WIDTH] : '0;
  assign instr_pc    = instr_valid ? head[PC_WIDTH-1:0] : '0;

`ifdef FETCH_PERF_EN
  // A pop coinciding with a redirect is discarded and not counted as fetched.
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      fetch_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (pop && !redirect) fetch_cnt <= fetch_cnt + 32'd1;
      if (redirect)         flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order latency memory model plus a program-order stream reference.
module tb_fetch_unit;

  localparam int unsigned PCW   = 16;
  localparam int unsigned IW    = 32;
  localparam int unsigned DEPTH = 4;

  logic           sysclk = 1'b0;
  logic           rst, halt, redirect, mem_req_ready, mem_resp_valid, instr_ready;
  logic [PCW-1:0] redirect_pc, mem_req_addr, instr_pc;
  logic [IW-1:0]  mem_resp_data, instr;
  logic           mem_req_valid, instr_valid;
`ifdef FETCH_PERF_EN
  logic [31:0]    fetch_cnt, flush_cnt;
`endif

  fetch_unit #(
    .PC_WIDTH    (PCW),
    .INSTR_WIDTH (IW),
    .FIFO_DEPTH  (DEPTH),
    .RESET_PC    (16'h0000)
  ) dut (
    .sysclk         (sysclk),
    .rst            (rst),
    .halt           (halt),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
`ifdef FETCH_PERF_EN
    ,
    .fetch_cnt      (fetch_cnt),
    .flush_cnt      (flush_cnt)
`endif
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    logic [PCW-1:0] addr;
    int             due;
    int             epoch;
  } mreq_t;

  mreq_t          mq[$];
  int             n_cmp, n_bad, cyc, epoch, occ, last_due;
  int             lat_min, lat_max, p_ready, p_iready, p_redir, p_halt;
  int             n_acc, n_pop, n_stale_drop;
  bit             rand_mode, first_req_seen, first_pop_seen, wrap_seen;
  bit             last_deliver, last_pop_possible;
  logic [PCW-1:0] exp_req, exp_pc, first_req, first_pop, prev_req;

  function automatic logic [IW-1:0] mem_word(input logic [PCW-1:0] a);
    return {a ^ 16'h5A5A, a};
  endfunction

  function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endfunction

  // Async reset: outputs must be at reset values before any clock edge.
  task automatic apply_reset();
    rst            = 1'b0;
    halt           = 1'b0;
    redirect       = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    #1;
    chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_req_addr", 32'(mem_req_addr), 32'h0000);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", 32'(instr_pc), 32'd0);
`ifdef FETCH_PERF_EN
    chk("rst_fetch_cnt", fetch_cnt, 32'd0);
    chk("rst_flush_cnt", flush_cnt, 32'd0);
`endif
    mq.delete();
    occ            = 0;
    exp_req        = '0;
    exp_pc         = '0;
    last_due       = 0;
    epoch++;
    first_req_seen = 1'b0;
    first_pop_seen = 1'b0;
    @(posedge sysclk);
    #1;
    rst = 1'b1;
  endtask

  // One clock cycle: drive inputs, deliver due memory response, check, update reference.
  task automatic tick();
    mreq_t d;
    bit    dlv, exp_v, popd;
    int    cur_in, stale, lat;
    if (rand_mode) begin
      mem_req_ready = int'($urandom_range(99, 0)) < p_ready;
      instr_ready   = int'($urandom_range(99, 0)) < p_iready;
      halt          = int'($urandom_range(99, 0)) < p_halt;
      redirect      = int'($urandom_range(99, 0)) < p_redir;
      redirect_pc   = {14'($urandom), 2'b00};
    end
    dlv = 1'b0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      d   = mq.pop_front();
      dlv = 1'b1;
    end
    mem_resp_valid = dlv;
    mem_resp_data  = dlv ? mem_word(d.addr) : '0;
    #3;
    cur_in = 0;
    stale  = 0;
    foreach (mq[i]) begin
      if (mq[i].epoch == epoch) cur_in++;
      else stale++;
    end
    if (dlv) begin
      if (d.epoch == epoch) cur_in++;
      else stale++;
    end
    exp_v = !halt && !redirect && (stale == 0) && (occ + cur_in < int'(DEPTH));
    chk("req_valid", 32'(mem_req_valid), 32'(exp_v));
    chk("instr_valid", 32'(instr_valid), 32'(occ > 0));
    if (mem_req_valid && mem_req_ready) begin
      chk("req_addr", 32'(mem_req_addr), 32'(exp_req));
      if (mem_req_addr == 16'h0000 && prev_req == 16'hFFFC) wrap_seen = 1'b1;
      prev_req = mem_req_addr;
      if (!first_req_seen) begin
        first_req      = mem_req_addr;
        first_req_seen = 1'b1;
      end
      lat      = int'($urandom_range(lat_max, lat_min));
      last_due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      mq.push_back('{mem_req_addr, last_due, epoch});
      exp_req += 16'd4;
      n_acc++;
    end
    popd = instr_valid && instr_ready && !redirect;
    if (popd) begin
      chk("instr_pc", 32'(instr_pc), 32'(exp_pc));
      chk("instr", instr, mem_word(exp_pc));
      if (!first_pop_seen) begin
        first_pop      = instr_pc;
        first_pop_seen = 1'b1;
      end
      exp_pc += 16'd4;
      n_pop++;
    end
    last_deliver      = dlv;
    last_pop_possible = instr_valid && instr_ready;
    if (dlv && d.epoch != epoch) n_stale_drop++;
    if (redirect) begin
      occ            = 0;
      epoch++;
      exp_req        = redirect_pc;
      exp_pc         = redirect_pc;
      first_req_seen = 1'b0;
      first_pop_seen = 1'b0;
    end else begin
      occ = occ + ((dlv && d.epoch == epoch) ? 1 : 0) - (popd ? 1 : 0);
    end
    @(posedge sysclk);
    #1;
    cyc++;
    if (!rand_mode) redirect = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0; epoch = 0; occ = 0; last_due = 0;
    n_acc = 0; n_pop = 0; n_stale_drop = 0;
    rand_mode = 1'b0; wrap_seen = 1'b0; prev_req = '0;
    first_req = '0; first_pop = '0;
    lat_min = 1; lat_max = 1;
    p_ready = 100; p_iready = 100; p_redir = 0; p_halt = 0;
    mem_req_ready = 1'b1; instr_ready = 1'b1; redirect_pc = '0;
    apply_reset();

    // Streaming with single-cycle memory: one instruction per cycle after a 2-cycle fill.
    n_pop = 0;
    repeat (20) tick();
    chk("t1_pops", 32'(n_pop), 32'd18);

    // Decode stalled: credit caps accepted requests at the FIFO depth.
    instr_ready = 1'b0;
    apply_reset();
    n_acc = 0;
    repeat (10) tick();
    chk("t2_acc_full", 32'(n_acc), 32'd4);
    chk("t2_valid_low", 32'(mem_req_valid), 32'd0);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    repeat (5) tick();
    chk("t2_acc_one", 32'(n_acc), 32'd5);

    // Redirect with two requests in flight at 3-cycle latency.
    instr_ready = 1'b1;
    lat_min = 3; lat_max = 3;
    apply_reset();
    repeat (2) tick();
    chk("t3_inflight", 32'(mq.size()), 32'd2);
    n_stale_drop = 0;
    redirect = 1'b1; redirect_pc = 16'h0100;
    tick();
    repeat (12) tick();
    chk("t3_dropped", 32'(n_stale_drop), 32'd2);
    chk("t3_req_seen", 32'(first_req_seen), 32'd1);
    chk("t3_first_req", 32'(first_req), 32'h0100);
    chk("t3_pop_seen", 32'(first_pop_seen), 32'd1);
    chk("t3_first_pc", 32'(first_pop), 32'h0100);

    // Redirect coinciding with a response and a pop.
    lat_min = 1; lat_max = 1;
    apply_reset();
    repeat (5) tick();
    redirect = 1'b1; redirect_pc = 16'h0200;
    tick();
    chk("t4_resp_at_redirect", 32'(last_deliver), 32'd1);
    chk("t4_pop_at_redirect", 32'(last_pop_possible), 32'd1);
    chk("t4_flushed", 32'(instr_valid), 32'd0);
    repeat (6) tick();
    chk("t4_pop_seen", 32'(first_pop_seen), 32'd1);
    chk("t4_first_pc", 32'(first_pop), 32'h0200);

    // Address wrap at the top of the PC space, then halt while the FIFO drains.
    wrap_seen = 1'b0;
    redirect = 1'b1; redirect_pc = 16'hFFF8;
    tick();
    repeat (8) tick();
    chk("t5_wrap", 32'(wrap_seen), 32'd1);
    halt = 1'b1;
    n_acc = 0; n_pop = 0;
    repeat (8) tick();
    chk("t5_halt_acc", 32'(n_acc), 32'd0);
    chk("t5_halt_drain", 32'(n_pop > 0), 32'd1);
    halt = 1'b0;

    // Randomized phases with varying latency, backpressure, halts and redirects.
    rand_mode = 1'b1;
    n_pop = 0;
    for (int ph = 0; ph < 6; ph++) begin
      lat_min  = int'($urandom_range(3, 1));
      lat_max  = lat_min + int'($urandom_range(3, 0));
      p_ready  = int'($urandom_range(100, 30));
      p_iready = int'($urandom_range(100, 20));
      p_redir  = int'($urandom_range(12, 2));
      p_halt   = int'($urandom_range(25, 0));
      repeat (300) tick();
    end
    chk("rand_progress", 32'(n_pop > 50), 32'd1);
    rand_mode = 1'b0;
    halt = 1'b0; redirect = 1'b0; mem_req_ready = 1'b1; instr_ready = 1'b1;

    // Reset asserted while draining stale responses.
    lat_min = 4; lat_max = 4;
    apply_reset();
    repeat (3) tick();
    redirect = 1'b1; redirect_pc = 16'h0040;
    tick();
    chk("t6_draining", 32'(mem_req_valid), 32'd0);
    lat_min = 1; lat_max = 1;
    apply_reset();
    repeat (3) tick();
    chk("t6_req_seen", 32'(first_req_seen), 32'd1);
    chk("t6_first_req", 32'(first_req), 32'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
